// File: rtl/nx_ram_arbiter.sv
// nx_ram_arbiter
// Round-robin arbiter sharing one nx_ram port between REQUESTERS clients.
// A single winner per cycle is chosen combinationally from i_req_valid,
// starting the search at the round-robin pointer. The RAM port is driven
// combinationally from the winner. Read responses return RD_LATENCY
// cycles after acceptance, tagged with a one-hot per-client strobe.
//
// Optional feature macro: NX_RAM_ARBITER_LOCK_EN
//   defined   : ARB/LOCKED FSM; a client transferring with i_req_lock=1
//               keeps exclusive grant until it drops lock or valid.
//   undefined : pure round-robin, i_req_lock ignored.
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_req_valid/o_req_ready per-client handshake (ready one-hot or zero)
//   i_req_addr/_wr_data     per-client address and write data
//   i_req_wr_en             per-client 1=write, 0=read
//   i_req_lock              per-client grant hold (lock build only)
//   o_rsp_valid/o_rsp_data  one-hot read strobe, shared read data
//   o_ram_en/_wr_en/_addr/_wr_data, i_ram_rd_data   RAM port
module nx_ram_arbiter #(
    parameter int REQUESTERS    = 4,
    parameter int ADDRESS_WIDTH = 10,
    parameter int DATA_WIDTH    = 32,
    parameter int RD_LATENCY    = 1,
    parameter int ID_WIDTH      = $clog2(REQUESTERS)
) (
    input  logic                                      i_clk,
    input  logic                                      i_rst_n,
    input  logic [REQUESTERS-1:0]                     i_req_valid,
    output logic [REQUESTERS-1:0]                     o_req_ready,
    input  logic [REQUESTERS-1:0][ADDRESS_WIDTH-1:0]  i_req_addr,
    input  logic [REQUESTERS-1:0][DATA_WIDTH-1:0]     i_req_wr_data,
    input  logic [REQUESTERS-1:0]                     i_req_wr_en,
    input  logic [REQUESTERS-1:0]                     i_req_lock,
    output logic [REQUESTERS-1:0]                     o_rsp_valid,
    output logic [DATA_WIDTH-1:0]                     o_rsp_data,
    output logic                                      o_ram_en,
    output logic                                      o_ram_wr_en,
    output logic [ADDRESS_WIDTH-1:0]                  o_ram_addr,
    output logic [DATA_WIDTH-1:0]                     o_ram_wr_data,
    input  logic [DATA_WIDTH-1:0]                     i_ram_rd_data
);

    // Search req starting at start, wrapping; returns {found, index}.
    function automatic logic [ID_WIDTH:0] rr_pick(
        input logic [REQUESTERS-1:0] req,
        input logic [ID_WIDTH-1:0]   start
    );
        logic [ID_WIDTH:0] res;
        int                idx;
        res = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            idx = (int'(start) + i) % REQUESTERS;
            if (!res[ID_WIDTH] && req[idx]) begin
                res = {1'b1, idx[ID_WIDTH-1:0]};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // (id + 1) mod REQUESTERS, valid for non-power-of-two client counts.
    function automatic logic [ID_WIDTH-1:0] inc_mod(input logic [ID_WIDTH-1:0] id);
        if (id == ID_WIDTH'(REQUESTERS - 1)) begin
            return '0;
        end else begin
            return id + ID_WIDTH'(1);
        end
    endfunction

    function automatic logic [REQUESTERS-1:0] onehot(input logic [ID_WIDTH-1:0] id);
        logic [REQUESTERS-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    logic [ID_WIDTH-1:0]                   r_rr;
    logic [RD_LATENCY-1:0][REQUESTERS-1:0] r_rsp_pipe;

    logic [REQUESTERS-1:0] w_eligible;
    logic [ID_WIDTH:0]     w_pick;
    logic                  w_found;
    logic [ID_WIDTH-1:0]   w_win_id;
    logic [REQUESTERS-1:0] w_ready;
    logic                  w_read_xfer;
    logic [ID_WIDTH-1:0]   w_rr_next;

`ifdef NX_RAM_ARBITER_LOCK_EN
    typedef enum logic [0:0] {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ID_WIDTH-1:0] r_owner;
    logic [ID_WIDTH-1:0] w_owner_next;

    // While locked only the owner may compete for the port.
    always_comb begin
        if (r_state == ST_LOCKED) begin
            w_eligible = i_req_valid & onehot(r_owner);
        end else begin
            w_eligible = i_req_valid;
        end
    end

    // Lock FSM next state: enter on a locking transfer, leave when the
    // owner drops lock or valid.
    always_comb begin
        w_state_next = r_state;
        w_owner_next = r_owner;
        case (r_state)
            ST_ARB: begin
                if (w_found && i_req_lock[w_win_id]) begin
                    w_state_next = ST_LOCKED;
                    w_owner_next = w_win_id;
                end else begin
                    w_state_next = ST_ARB;
                end
            end
            ST_LOCKED: begin
                if (i_req_valid[r_owner] && i_req_lock[r_owner]) begin
                    w_state_next = ST_LOCKED;
                end else begin
                    w_state_next = ST_ARB;
                end
            end
            default: begin
                w_state_next = ST_ARB;
            end
        endcase
    end

    // Pointer next: while locked it always parks just past the owner, so
    // leaving the lock (by release or by dropping valid) resumes there.
    always_comb begin
        if (r_state == ST_LOCKED) begin
            w_rr_next = inc_mod(r_owner);
        end else if (w_found) begin
            w_rr_next = inc_mod(w_win_id);
        end else begin
            w_rr_next = r_rr;
        end
    end

    // Lock FSM state and owner registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_ARB;
            r_owner <= '0;
        end else begin
            r_state <= w_state_next;
            r_owner <= w_owner_next;
        end
    end
`else
    logic w_lock_unused;
    assign w_lock_unused = ^i_req_lock;
    assign w_eligible    = i_req_valid;

    // Pointer advances past the winner after every transfer.
    always_comb begin
        if (w_found) begin
            w_rr_next = inc_mod(w_win_id);
        end else begin
            w_rr_next = r_rr;
        end
    end
`endif

    assign w_pick      = rr_pick(w_eligible, r_rr);
    assign w_found     = w_pick[ID_WIDTH];
    assign w_win_id    = w_pick[ID_WIDTH-1:0];
    assign w_read_xfer = w_found && !i_req_wr_en[w_win_id];

    // Grant and RAM drive from the winner; everything zero when idle.
    // Ready depends only on inputs and state, never on other outputs.
    always_comb begin
        if (w_found) begin
            w_ready       = onehot(w_win_id);
            o_ram_en      = 1'b1;
            o_ram_wr_en   = i_req_wr_en[w_win_id];
            o_ram_addr    = i_req_addr[w_win_id];
            o_ram_wr_data = i_req_wr_data[w_win_id];
        end else begin
            w_ready       = '0;
            o_ram_en      = 1'b0;
            o_ram_wr_en   = 1'b0;
            o_ram_addr    = '0;
            o_ram_wr_data = '0;
        end
    end

    assign o_req_ready = w_ready;

    // Round-robin pointer and response pipeline. Each stage holds the
    // one-hot client strobe, which encodes {valid, id} in one field.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rr       <= '0;
            r_rsp_pipe <= '0;
        end else begin
            r_rr          <= w_rr_next;
            r_rsp_pipe[0] <= w_read_xfer ? w_ready : '0;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_rsp_pipe[i] <= r_rsp_pipe[i-1];
            end
        end
    end

    assign o_rsp_valid = r_rsp_pipe[RD_LATENCY-1];
    assign o_rsp_data  = i_ram_rd_data;

endmodule

// File: tb/tb_nx_ram_arbiter.sv
module tb_nx_ram_arbiter;
    localparam int N  = 4;
    localparam int AW = 10;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [N-1:0]         req_valid, req_wr_en, req_lock;
    logic [N-1:0][AW-1:0] req_addr;
    logic [N-1:0][DW-1:0] req_wdata;

    logic [N-1:0]  rdy1, rsp_v1, rdy2, rsp_v2;
    logic [DW-1:0] rsp_d1, rsp_d2, wd1, wd2, rd1, rd2, rd2_q;
    logic          en1, we1, en2, we2;
    logic [AW-1:0] addr1, addr2;
    logic [DW-1:0] mem1 [0:(1<<AW)-1];
    logic [DW-1:0] mem2 [0:(1<<AW)-1];

    int checks   = 0;
    int failures = 0;

    nx_ram_arbiter #(.REQUESTERS(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(rdy1), .i_req_addr(req_addr),
        .i_req_wr_data(req_wdata), .i_req_wr_en(req_wr_en), .i_req_lock(req_lock),
        .o_rsp_valid(rsp_v1), .o_rsp_data(rsp_d1),
        .o_ram_en(en1), .o_ram_wr_en(we1), .o_ram_addr(addr1), .o_ram_wr_data(wd1),
        .i_ram_rd_data(rd1)
    );

    nx_ram_arbiter #(.REQUESTERS(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(rdy2), .i_req_addr(req_addr),
        .i_req_wr_data(req_wdata), .i_req_wr_en(req_wr_en), .i_req_lock(req_lock),
        .o_rsp_valid(rsp_v2), .o_rsp_data(rsp_d2),
        .o_ram_en(en2), .o_ram_wr_en(we2), .o_ram_addr(addr2), .o_ram_wr_data(wd2),
        .i_ram_rd_data(rd2)
    );

    // RAM with unregistered output (one cycle synchronous read).
    always @(posedge clk) begin
        if (en1) begin
            if (we1) mem1[addr1] <= wd1;
            else     rd1 <= mem1[addr1];
        end
    end

    // RAM with an extra output register (two cycle read).
    always @(posedge clk) begin
        if (en2) begin
            if (we2) mem2[addr2] <= wd2;
            else     rd2_q <= mem2[addr2];
        end
        rd2 <= rd2_q;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic set_idle();
        req_valid = '0; req_wr_en = '0; req_lock = '0;
        req_addr  = '0; req_wdata = '0;
    endtask

    task automatic set_req(input int k, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[k] = 1'b1;
        req_wr_en[k] = we;
        req_addr[k]  = a;
        req_wdata[k] = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_idle();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (rsp_v1 !== 4'b0000 || rsp_v2 !== 4'b0000) begin
            failures++; $display("FAIL reset_rsp: got %b/%b expected 0000", rsp_v1, rsp_v2);
        end
        checks++;
        if ({rdy1, en1, we1, addr1, wd1} !== '0) begin
            failures++; $display("FAIL reset_idle_port: got rdy=%b en=%b addr=%h wd=%h expected zeros", rdy1, en1, addr1, wd1);
        end
        req_valid = 4'b1010; req_addr[1] = 10'h03A; req_addr[3] = 10'h155;
        #1;
        checks++;
        if (rdy1 !== 4'b0010 || en1 !== 1'b1 || addr1 !== 10'h03A) begin
            failures++; $display("FAIL reset_first_grant: got rdy=%b en=%b addr=%h expected 0010 1 03a", rdy1, en1, addr1);
        end
        set_idle();
        @(negedge clk);
    endtask

    task automatic test_single_read();
        set_idle();
        set_req(1, 1'b1, 10'd5, 32'hDEADBEEF);
        #1;
        checks++;
        if (rdy1 !== 4'b0010 || en1 !== 1'b1 || we1 !== 1'b1 || addr1 !== 10'd5 || wd1 !== 32'hDEADBEEF) begin
            failures++; $display("FAIL single_write_drive: got rdy=%b en=%b we=%b addr=%h wd=%h expected 0010 1 1 005 deadbeef", rdy1, en1, we1, addr1, wd1);
        end
        @(negedge clk);
        set_idle();
        set_req(1, 1'b0, 10'd5, 32'h0);
        #1;
        checks++;
        if (rsp_v1 !== 4'b0000) begin
            failures++; $display("FAIL single_write_no_rsp: got %b expected 0000", rsp_v1);
        end
        checks++;
        if (rdy1 !== 4'b0010 || we1 !== 1'b0 || addr1 !== 10'd5) begin
            failures++; $display("FAIL single_read_drive: got rdy=%b we=%b addr=%h expected 0010 0 005", rdy1, we1, addr1);
        end
        @(negedge clk);
        set_idle();
        #1;
        checks++;
        if (rsp_v1 !== 4'b0010 || rsp_d1 !== 32'hDEADBEEF) begin
            failures++; $display("FAIL single_read_rsp: got v=%b d=%h expected 0010 deadbeef", rsp_v1, rsp_d1);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rsp_v1 !== 4'b0000) begin
            failures++; $display("FAIL single_read_rsp_once: got %b expected 0000", rsp_v1);
        end
    endtask

    task automatic test_contention();
        int cnt [N];
        logic [N-1:0] exp_v;
        for (int k = 0; k < N; k++) cnt[k] = 0;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            set_idle();
            if (c < 8) begin
                for (int k = 0; k < N; k++) set_req(k, 1'b0, AW'(k), '0);
            end
            #1;
            if (c < 8) begin
                checks++;
                if (rdy1 !== (4'b0001 << (c % 4))) begin
                    failures++; $display("FAIL contention_grant[%0d]: got %b expected %b", c, rdy1, 4'b0001 << (c % 4));
                end
            end
            exp_v = (c == 0) ? 4'b0000 : (4'b0001 << ((c - 1) % 4));
            checks++;
            if (rsp_v1 !== exp_v) begin
                failures++; $display("FAIL contention_rsp[%0d]: got %b expected %b", c, rsp_v1, exp_v);
            end
            for (int k = 0; k < N; k++) if (rsp_v1[k] === 1'b1) cnt[k]++;
            @(negedge clk);
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (cnt[k] != 2) begin
                failures++; $display("FAIL contention_count[%0d]: got %0d expected 2", k, cnt[k]);
            end
        end
    endtask

    task automatic test_registered();
        int            tk [9] = '{0, 3, 1, 0, 2, 3, -1, -1, -1};
        logic          tw [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [AW-1:0] ta [9] = '{10'd7, 10'd9, 10'd12, 10'd9, 10'd13, 10'd7, 10'd0, 10'd0, 10'd0};
        logic [3:0]    ev [9] = '{4'b0000, 4'b0000, 4'b0001, 4'b1000, 4'b0000, 4'b0001, 4'b0000, 4'b1000, 4'b0000};
        logic [DW-1:0] ed [9] = '{32'h0, 32'h0, 32'h11111111, 32'h22222222, 32'h0, 32'h22222222, 32'h0, 32'h11111111, 32'h0};
        logic [N-1:0]  exp_r;
        do_reset();
        set_idle(); set_req(1, 1'b1, 10'd7, 32'h11111111);
        @(negedge clk);
        set_idle(); set_req(2, 1'b1, 10'd9, 32'h22222222);
        @(negedge clk);
        for (int c = 0; c < 9; c++) begin
            set_idle();
            if (tk[c] >= 0) set_req(tk[c], tw[c], ta[c], 32'h33333333);
            #1;
            exp_r = (tk[c] >= 0) ? (4'b0001 << tk[c]) : 4'b0000;
            checks++;
            if (rdy2 !== exp_r) begin
                failures++; $display("FAIL lat2_grant[%0d]: got %b expected %b", c, rdy2, exp_r);
            end
            checks++;
            if (rsp_v2 !== ev[c] || (ev[c] != 4'b0000 && rsp_d2 !== ed[c])) begin
                failures++; $display("FAIL lat2_rsp[%0d]: got v=%b d=%h expected v=%b d=%h", c, rsp_v2, rsp_d2, ev[c], ed[c]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_lock();
`ifdef NX_RAM_ARBITER_LOCK_EN
        logic [N-1:0] tv [5] = '{4'b0100, 4'b0111, 4'b0111, 4'b1011, 4'b0011};
        logic [N-1:0] tl [5] = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
        logic [N-1:0] eg [5] = '{4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            set_idle();
            req_valid = tv[c];
            req_lock  = tl[c];
            #1;
            checks++;
            if (rdy1 !== eg[c]) begin
                failures++; $display("FAIL lock_grant[%0d]: got %b expected %b", c, rdy1, eg[c]);
            end
            @(negedge clk);
        end
`else
        do_reset();
        for (int c = 0; c < 6; c++) begin
            set_idle();
            req_valid = 4'b0111;
            req_lock  = 4'b0100;
            #1;
            checks++;
            if (rdy1 !== (4'b0001 << (c % 3))) begin
                failures++; $display("FAIL nolock_grant[%0d]: got %b expected %b", c, rdy1, 4'b0001 << (c % 3));
            end
            @(negedge clk);
        end
`endif
        set_idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_idle(); set_req(2, 1'b0, 10'd7, '0);
        @(negedge clk);
        set_idle(); set_req(1, 1'b0, 10'd9, '0);
        #1;
        checks++;
        if (rdy1 !== 4'b0010) begin
            failures++; $display("FAIL midrst_pre_grant: got %b expected 0010", rdy1);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        set_idle();
        #1;
        checks++;
        if (rsp_v1 !== 4'b0000 || rsp_v2 !== 4'b0000) begin
            failures++; $display("FAIL midrst_async_clear: got %b/%b expected 0000", rsp_v1, rsp_v2);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (rsp_v1 !== 4'b0000 || rsp_v2 !== 4'b0000) begin
                failures++; $display("FAIL midrst_no_rsp[%0d]: got %b/%b expected 0000", c, rsp_v1, rsp_v2);
            end
            @(negedge clk);
        end
        req_valid = 4'b1010;
        #1;
        checks++;
        if (rdy1 !== 4'b0010 || rdy2 !== 4'b0010) begin
            failures++; $display("FAIL midrst_ptr_zero: got %b/%b expected 0010", rdy1, rdy2);
        end
        set_idle();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();
        test_reset();
        test_single_read();
        test_contention();
        test_registered();
        test_lock();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
